// File: rtl/fc_layer_param.sv
// Fully-connected layer controller: y[r] = sat(act(W[r].a + b[r])). Per neuron 2 + ROM + MAC + 2 cycles.
// No backpressure: waits on rom_valid/mac_valid. ena=0 releases the buses and aborts to IDLE.
module fc_layer_param #(
  parameter int BIT         = 16,
  parameter int N_IN        = 128,
  parameter int N_OUT       = 128,
  parameter int ACC_W       = 2*BIT-1,
  parameter int BIAS_SHIFT  = 10,
  parameter int OUT_SHIFT   = 10,
  parameter int ROW_REVERSE = 1,
  parameter int ADDR_W      = 11
) (
  input  logic                    clk,
  input  logic                    iRst_n,
  input  logic                    ena,
  input  logic                    start,
  input  logic                    relu_en,
  input  logic [7:0]              n_out_cfg,
  input  logic [ADDR_W-1:0]       rom_addr_base,
  input  logic [ADDR_W-1:0]       bias_addr_base,
  output logic [ADDR_W-1:0]       addr_to_rom,
  output logic                    rom_req,
  input  logic                    rom_valid,
  input  logic [N_IN*BIT-1:0]     data_from_rom,
  input  logic [N_IN*BIT-1:0]     data_from_ram,
  output logic [N_IN*BIT-1:0]     opr1_to_MultAdder,
  output logic [N_IN*BIT-1:0]     opr2_to_MultAdder,
  output logic                    mac_start,
  input  logic                    mac_valid,
  input  logic [ACC_W-1:0]        data_from_MultAdder,
  output logic [N_OUT*BIT-1:0]    data_to_ram,
  output logic                    busy,
  output logic                    done,
  output logic                    sat_flag
);
  localparam int WORD_W     = N_IN*BIT;
  localparam int BIAS_WORDS = (N_OUT + N_IN - 1) / N_IN;
  localparam int CNT_W      = $clog2(N_OUT + 1);
  localparam int K_W        = $clog2(BIAS_WORDS + 1);
  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((1 << (BIT-1)) - 1);
  localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W+1)'(-(1 << (BIT-1)));

  typedef enum logic [3:0] {
    S_IDLE, S_BIAS_REQ, S_BIAS_WAIT, S_ROW_REQ, S_ROW_WAIT,
    S_MAC_WAIT, S_ACCUM, S_NEXT, S_DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         n_q, n_d, row_q, row_d;
  logic [K_W-1:0]           nw_q, nw_d, k_q, k_d;
  logic [ADDR_W-1:0]        rom_base_q, rom_base_d, bias_base_q, bias_base_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic                     rom_req_q, rom_req_d, mac_start_q, mac_start_d;
  logic [WORD_W-1:0]        opr1_q, opr1_d, opr2_q, opr2_d;
  logic [ACC_W-1:0]         mac_q, mac_d;
  logic [BIAS_WORDS*WORD_W-1:0] bias_q, bias_d;
  logic [N_OUT*BIT-1:0]     data_q, data_d;
  logic                     busy_q, busy_d, done_q, done_d, sat_q, sat_d;

  int                       n_eff;
  logic [BIT-1:0]           b_cur;
  logic signed [ACC_W:0]    mac_ext, bias_ext, acc, s;
  logic [BIT-1:0]           y;
  logic                     clamp;

  always_comb begin
    n_eff = (n_out_cfg == 8'd0 || int'(n_out_cfg) > N_OUT) ? N_OUT : int'(n_out_cfg);

    // Bias is sign-extended and aligned to the product scale before the add.
    b_cur    = bias_q[int'(row_q)*BIT +: BIT];
    mac_ext  = {mac_q[ACC_W-1], mac_q};
    bias_ext = {{(ACC_W+1-BIT){b_cur[BIT-1]}}, b_cur};
    acc      = mac_ext + (bias_ext <<< BIAS_SHIFT);
    s        = acc >>> OUT_SHIFT;
    clamp    = 1'b0;
    if (relu_en && s[ACC_W]) begin
      y = '0;
    end else if (s > SAT_MAX) begin
      y = SAT_MAX[BIT-1:0];
      clamp = 1'b1;
    end else if (s < SAT_MIN) begin
      y = SAT_MIN[BIT-1:0];
      clamp = 1'b1;
    end else begin
      y = s[BIT-1:0];
    end

    state_d     = state_q;
    n_d         = n_q;
    nw_d        = nw_q;
    row_d       = row_q;
    k_d         = k_q;
    rom_base_d  = rom_base_q;
    bias_base_d = bias_base_q;
    addr_d      = addr_q;
    rom_req_d   = 1'b0;
    mac_start_d = 1'b0;
    opr1_d      = opr1_q;
    opr2_d      = opr2_q;
    mac_d       = mac_q;
    bias_d      = bias_q;
    data_d      = data_q;
    busy_d      = busy_q;
    done_d      = done_q;
    sat_d       = sat_q;

    case (state_q)
      S_IDLE: if (start) begin
        n_d         = CNT_W'(n_eff);
        nw_d        = K_W'((n_eff + N_IN - 1) / N_IN);
        rom_base_d  = rom_addr_base;
        bias_base_d = bias_addr_base;
        sat_d       = 1'b0;
        done_d      = 1'b0;
        busy_d      = 1'b1;
        k_d         = '0;
        state_d     = S_BIAS_REQ;
      end
      S_BIAS_REQ: state_d = S_BIAS_WAIT;
      S_BIAS_WAIT: if (rom_valid) begin
        bias_d[int'(k_q)*WORD_W +: WORD_W] = data_from_rom;
        k_d = k_q + K_W'(1);
        if (k_d < nw_q) begin
          state_d = S_BIAS_REQ;
        end else begin
          row_d   = '0;
          state_d = S_ROW_REQ;
        end
      end
      S_ROW_REQ: state_d = S_ROW_WAIT;
      S_ROW_WAIT: if (rom_valid) begin
        opr1_d      = data_from_ram;
        opr2_d      = data_from_rom;
        mac_start_d = 1'b1;
        state_d     = S_MAC_WAIT;
      end
      S_MAC_WAIT: if (mac_valid) begin
        mac_d   = data_from_MultAdder;
        state_d = S_ACCUM;
      end
      S_ACCUM: begin
        data_d[int'(row_q)*BIT +: BIT] = y;
        if (clamp) sat_d = 1'b1;
        row_d   = row_q + CNT_W'(1);
        state_d = S_NEXT;
      end
      S_NEXT:  state_d = (row_q < n_q) ? S_ROW_REQ : S_DONE;
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (!ena) begin
      state_d     = S_IDLE;
      done_d      = 1'b0;
      busy_d      = 1'b0;
      mac_start_d = 1'b0;
    end

    // Address and strobe are registered on entry so they are presented during the REQ state.
    if (state_d == S_BIAS_REQ) begin
      addr_d    = bias_base_d + ADDR_W'(k_d);
      rom_req_d = 1'b1;
    end else if (state_d == S_ROW_REQ) begin
      addr_d    = (ROW_REVERSE != 0) ? rom_base_d + ADDR_W'(N_OUT - 1 - int'(row_d))
                                     : rom_base_d + ADDR_W'(row_d);
      rom_req_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q     <= S_IDLE;
      n_q         <= '0;
      nw_q        <= '0;
      row_q       <= '0;
      k_q         <= '0;
      rom_base_q  <= '0;
      bias_base_q <= '0;
      addr_q      <= '0;
      rom_req_q   <= 1'b0;
      mac_start_q <= 1'b0;
      opr1_q      <= '0;
      opr2_q      <= '0;
      mac_q       <= '0;
      bias_q      <= '0;
      data_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      nw_q        <= nw_d;
      row_q       <= row_d;
      k_q         <= k_d;
      rom_base_q  <= rom_base_d;
      bias_base_q <= bias_base_d;
      addr_q      <= addr_d;
      rom_req_q   <= rom_req_d;
      mac_start_q <= mac_start_d;
      opr1_q      <= opr1_d;
      opr2_q      <= opr2_d;
      mac_q       <= mac_d;
      bias_q      <= bias_d;
      data_q      <= data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      sat_q       <= sat_d;
    end
  end

  assign addr_to_rom       = ena ? addr_q : {ADDR_W{1'bz}};
  assign opr1_to_MultAdder = ena ? opr1_q : {WORD_W{1'bz}};
  assign opr2_to_MultAdder = ena ? opr2_q : {WORD_W{1'bz}};
  assign rom_req           = rom_req_q;
  assign mac_start         = mac_start_q;
  assign data_to_ram       = data_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign sat_flag          = sat_q;
endmodule

// File: tb/tb_fc_layer_param.sv
// Directed bench for fc_layer_param: two instances (row order reversed / forward) share a
// ROM model with 2-cycle latency and a MultAdder model with 3-cycle latency.
module tb_fc_layer_param;
  localparam int BIT = 8, N_IN = 4, N_OUT = 6, ACC_W = 15, ADDR_W = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, ena, start, relu_en;
  logic [7:0]        n_cfg;
  logic [ADDR_W-1:0] rom_base, bias_base;
  logic [31:0]       ram_data;
  logic [7:0]        bias_b;
  logic [ACC_W-1:0]  mac_val;

  wire               rom_valid, mac_valid;
  wire [31:0]        rom_data;
  wire [ACC_W-1:0]   mac_data;
  wire [ADDR_W-1:0]  addr_r, addr_f;
  wire               req_r, req_f, ms_r, ms_f;
  wire [31:0]        o1_r, o2_r, o1_f, o2_f;
  wire [47:0]        ram_r, ram_f;
  wire               busy_r, busy_f, done_r, done_f, sat_r, sat_f;

  fc_layer_param #(.BIT(BIT), .N_IN(N_IN), .N_OUT(N_OUT), .ACC_W(ACC_W), .BIAS_SHIFT(4),
                   .OUT_SHIFT(4), .ROW_REVERSE(1), .ADDR_W(ADDR_W)) u_dut (
    .clk(clk), .iRst_n(rst_n), .ena(ena), .start(start), .relu_en(relu_en),
    .n_out_cfg(n_cfg), .rom_addr_base(rom_base), .bias_addr_base(bias_base),
    .addr_to_rom(addr_r), .rom_req(req_r), .rom_valid(rom_valid), .data_from_rom(rom_data),
    .data_from_ram(ram_data), .opr1_to_MultAdder(o1_r), .opr2_to_MultAdder(o2_r),
    .mac_start(ms_r), .mac_valid(mac_valid), .data_from_MultAdder(mac_data),
    .data_to_ram(ram_r), .busy(busy_r), .done(done_r), .sat_flag(sat_r));

  fc_layer_param #(.BIT(BIT), .N_IN(N_IN), .N_OUT(N_OUT), .ACC_W(ACC_W), .BIAS_SHIFT(4),
                   .OUT_SHIFT(4), .ROW_REVERSE(0), .ADDR_W(ADDR_W)) u_dut_fwd (
    .clk(clk), .iRst_n(rst_n), .ena(ena), .start(start), .relu_en(relu_en),
    .n_out_cfg(n_cfg), .rom_addr_base(rom_base), .bias_addr_base(bias_base),
    .addr_to_rom(addr_f), .rom_req(req_f), .rom_valid(rom_valid), .data_from_rom(rom_data),
    .data_from_ram(ram_data), .opr1_to_MultAdder(o1_f), .opr2_to_MultAdder(o2_f),
    .mac_start(ms_f), .mac_valid(mac_valid), .data_from_MultAdder(mac_data),
    .data_to_ram(ram_f), .busy(busy_f), .done(done_f), .sat_flag(sat_f));

  logic [1:0]        rp = '0;
  logic [2:0]        mp = '0;
  logic [ADDR_W-1:0] ra0 = '0, ra1 = '0;
  logic [ADDR_W-1:0] log_r[$], log_f[$];

  always @(posedge clk) begin
    rp  <= {rp[0], req_r};
    ra0 <= addr_r;
    ra1 <= ra0;
    mp  <= {mp[1:0], ms_r};
    if (req_r === 1'b1) log_r.push_back(addr_r);
    if (req_f === 1'b1) log_f.push_back(addr_f);
  end

  assign rom_valid = rp[1];
  assign rom_data  = (ra1 == bias_base || ra1 == bias_base + 11'd1) ? {4{bias_b}} : 32'h1122_3344;
  assign mac_valid = mp[2];
  assign mac_data  = mac_val;

  int nvec = 0, nerr = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // A released bus reads as Z, or as 0 where Z is not representable.
  function automatic logic released(input logic [31:0] v);
    return (v === 32'bz) || (v === 32'h0);
  endfunction

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done_r !== 1'b1 && n < 500) begin @(negedge clk); n++; end
    check("pass_done", {63'd0, done_r}, 64'd1);
  endtask

  task automatic setup(input logic [7:0] n, input logic [ACC_W-1:0] mac, input logic [7:0] b,
                       input logic relu);
    @(negedge clk);
    n_cfg = n; mac_val = mac; bias_b = b; relu_en = relu;
    log_r.delete(); log_f.delete();
  endtask

  task automatic run_pass(input logic [7:0] n, input logic [ACC_W-1:0] mac, input logic [7:0] b,
                          input logic relu);
    setup(n, mac, b, relu);
    pulse_start();
    wait_done();
  endtask

  initial begin
    logic [10:0] exp_a;
    int nb, n;
    rst_n = 1'b0; ena = 1'b1; start = 1'b0; relu_en = 1'b0; n_cfg = 8'd6;
    rom_base = 11'h401; bias_base = 11'h100; ram_data = 32'h0403_0201;
    bias_b = 8'h10; mac_val = 15'h0030;
    #2;
    check("rst_done", {63'd0, done_r}, 64'd0);
    check("rst_busy", {63'd0, busy_r}, 64'd0);
    check("rst_sat", {63'd0, sat_r}, 64'd0);
    check("rst_req", {63'd0, req_r}, 64'd0);
    check("rst_mac_start", {63'd0, ms_r}, 64'd0);
    check("rst_ram", {16'd0, ram_r}, 64'd0);
    check("rst_addr", {53'd0, addr_r}, 64'd0);
    check("rst_opr1", {32'd0, o1_r}, 64'd0);
    #20 rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Basic pass, both row orders
    setup(8'd6, 15'h0030, 8'h10, 1'b0);
    pulse_start();
    check("basic_busy", {63'd0, busy_r}, 64'd1);
    check("basic_done_clr", {63'd0, done_r}, 64'd0);
    wait_done();
    check("basic_ram", {16'd0, ram_r}, 64'h1313_1313_1313);
    check("basic_ram_fwd", {16'd0, ram_f}, 64'h1313_1313_1313);
    check("basic_sat", {63'd0, sat_r}, 64'd0);
    check("basic_busy_end", {63'd0, busy_r}, 64'd0);
    check("rev_nreq", 64'(log_r.size()), 64'd8);
    check("fwd_nreq", 64'(log_f.size()), 64'd8);
    for (int i = 0; i < 8; i++) begin
      exp_a = (i < 2) ? 11'h100 + 11'(i) : 11'h406 - 11'(i - 2);
      check($sformatf("rev_addr%0d", i), {53'd0, log_r[i]}, {53'd0, exp_a});
      exp_a = (i < 2) ? 11'h100 + 11'(i) : 11'h401 + 11'(i - 2);
      check($sformatf("fwd_addr%0d", i), {53'd0, log_f[i]}, {53'd0, exp_a});
    end

    // Saturation and ReLU
    run_pass(8'd6, 15'sd12288, 8'h00, 1'b0);
    check("satpos_ram", {16'd0, ram_r}, 64'h7F7F_7F7F_7F7F);
    check("satpos_flag", {63'd0, sat_r}, 64'd1);
    run_pass(8'd6, -15'sd256, 8'h00, 1'b0);
    check("neg_ram", {16'd0, ram_r}, 64'hF0F0_F0F0_F0F0);
    check("neg_sat_clr", {63'd0, sat_r}, 64'd0);
    run_pass(8'd6, -15'sd256, 8'h00, 1'b1);
    check("relu_ram", {16'd0, ram_r}, 64'h0);
    check("relu_sat", {63'd0, sat_r}, 64'd0);
    run_pass(8'd6, -15'sd12288, 8'h00, 1'b0);
    check("satneg_ram", {16'd0, ram_r}, 64'h8080_8080_8080);
    check("satneg_flag", {63'd0, sat_r}, 64'd1);

    // Partial neuron count over a 0xAA preload
    run_pass(8'd6, -15'sd1376, 8'h00, 1'b0);
    check("preload_ram", {16'd0, ram_r}, 64'hAAAA_AAAA_AAAA);
    run_pass(8'd3, 15'h0030, 8'h10, 1'b0);
    check("partial_ram", {16'd0, ram_r}, 64'hAAAA_AA13_1313);
    check("partial_nreq", 64'(log_r.size()), 64'd4);
    nb = 0;
    foreach (log_r[i]) if (log_r[i] == 11'h100 || log_r[i] == 11'h101) nb++;
    check("partial_bias_reads", 64'(nb), 64'd1);

    // Abort with ena=0 while waiting on the MultAdder
    setup(8'd6, 15'h0030, 8'h10, 1'b0);
    pulse_start();
    n = 0;
    while (ms_r !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    check("abort_saw_mac_start", {63'd0, ms_r}, 64'd1);
    ena = 1'b0;
    @(posedge clk); #1;
    check("abort_addr_rel", {63'd0, released({21'd0, addr_r})}, 64'd1);
    check("abort_opr1_rel", {63'd0, released(o1_r)}, 64'd1);
    check("abort_opr2_rel", {63'd0, released(o2_r)}, 64'd1);
    check("abort_done", {63'd0, done_r}, 64'd0);
    check("abort_busy", {63'd0, busy_r}, 64'd0);
    check("abort_ram_hold", {16'd0, ram_r}, 64'hAAAA_AA13_1313);
    @(negedge clk); ena = 1'b1;
    repeat (10) @(negedge clk);
    check("abort_idle_busy", {63'd0, busy_r}, 64'd0);
    check("abort_idle_done", {63'd0, done_r}, 64'd0);
    check("abort_idle_ram", {16'd0, ram_r}, 64'hAAAA_AA13_1313);

    // Asynchronous reset mid-pass
    setup(8'd6, 15'sd12288, 8'h00, 1'b0);
    pulse_start();
    n = 0;
    while (sat_r !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    check("midrst_saw_sat", {63'd0, sat_r}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ram", {16'd0, ram_r}, 64'd0);
    check("midrst_sat", {63'd0, sat_r}, 64'd0);
    check("midrst_busy", {63'd0, busy_r}, 64'd0);
    check("midrst_done", {63'd0, done_r}, 64'd0);
    check("midrst_req", {63'd0, req_r}, 64'd0);
    check("midrst_mac_start", {63'd0, ms_r}, 64'd0);
    check("midrst_addr", {53'd0, addr_r}, 64'd0);
    check("midrst_opr2", {32'd0, o2_r}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (8) @(negedge clk);

    // Fresh pass; n_out_cfg=0 means all N_OUT neurons
    run_pass(8'd0, 15'h0030, 8'h10, 1'b0);
    check("fresh_ram", {16'd0, ram_r}, 64'h1313_1313_1313);
    check("fresh_sat", {63'd0, sat_r}, 64'd0);
    check("fresh_nreq", 64'(log_r.size()), 64'd8);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/fc_layer_param.md
Name: fc_layer_param

Overview:
- Parametrised fully-connected layer controller: y[r] = sat(act(W[r]·a + b[r])) for r = 0..n_out_cfg-1.
- Fetches packed bias words and one weight row per output neuron from the shared weight ROM.
- Drives the external N_IN-lane MultAdder with the weight row and the activation vector, then adds the aligned bias internally.
- Shifts, saturates and optionally applies ReLU, and packs results into a RAM-bound vector. Successor to the fixed 128x128 layer controller.

Parameters:
- BIT, 16, fixed-point width of weights, activations, biases and outputs.
- N_IN, 128, MultAdder lane count; weight-row and ROM-word width is N_IN*BIT.
- N_OUT, 128, maximum output neurons; data_to_ram width is N_OUT*BIT.
- ACC_W, 2*BIT-1, MultAdder result and accumulator width (signed).
- BIAS_SHIFT, 10, left shift aligning a bias to the product scale.
- OUT_SHIFT, 10, arithmetic right shift from accumulator to output scale.
- ROW_REVERSE, 1, 1: row r is read at rom_addr_base+(N_OUT-1-r); 0: at rom_addr_base+r.
- ADDR_W, 11, ROM address width.

Ports:
- clk  in  1  clock, rising edge.
- iRst_n  in  1  asynchronous active-low reset.
- ena  in  1  bus grant; 0 = release shared buses and abort to IDLE.
- start  in  1  one-cycle pulse that begins a layer pass (sampled in IDLE only).
- relu_en  in  1  1 = clamp negative results to 0.
- n_out_cfg  in  8  runtime neuron count, 1..N_OUT; latched at start.
- rom_addr_base  in  ADDR_W  first weight-row address; latched at start.
- bias_addr_base  in  ADDR_W  first bias-word address; latched at start.
- addr_to_rom  out  ADDR_W  ROM address; Z when ena=0.
- rom_req  out  1  one-cycle read strobe.
- rom_valid  in  1  data_from_rom valid; arrives 1 or more cycles after rom_req.
- data_from_rom  in  N_IN*BIT  ROM word.
- data_from_ram  in  N_IN*BIT  activation vector, stable for the whole pass.
- opr1_to_MultAdder  out  N_IN*BIT  activations; Z when ena=0.
- opr2_to_MultAdder  out  N_IN*BIT  weight row; Z when ena=0.
- mac_start  out  1  one-cycle strobe: operands valid.
- mac_valid  in  1  data_from_MultAdder valid.
- data_from_MultAdder  in  ACC_W  signed dot product.
- data_to_ram  out  N_OUT*BIT  packed results; neuron r occupies bits [r*BIT +: BIT].
- busy  out  1  high from the start-accept cycle until done.
- done  out  1  level; high from pass completion until the next start or abort.
- sat_flag  out  1  sticky; set if any neuron saturated this pass.

Behaviour:
- Reset (iRst_n=0, async): state=IDLE; done=busy=sat_flag=rom_req=mac_start=0; data_to_ram=0; addr_to_rom=0; opr1/opr2=0; rowCnt=0; bias registers=0.
- ena=0 (sync, highest priority after reset): state to IDLE; done, busy, rom_req and mac_start cleared; addr/opr buses Z; data_to_ram holds its value.
- Bias layout: BIAS_WORDS=ceil(N_OUT/N_IN) words. Word k holds biases k*N_IN .. k*N_IN+N_IN-1, lane j at bits [j*BIT +: BIT].
- IDLE:
  - start=1: latch configuration; clear sat_flag and done; set busy; k=0; go to BIAS_REQ.
  - start while busy is ignored.
- BIAS_REQ: addr_to_rom=bias_addr_base+k; rom_req=1 for one cycle; go to BIAS_WAIT.
- BIAS_WAIT: on rom_valid, store the word into bias slot k; k++. Go to BIAS_REQ if k<ceil(n_out_cfg/N_IN), else rowCnt=0 and go to ROW_REQ.
- ROW_REQ: addr_to_rom per ROW_REVERSE; rom_req=1; go to ROW_WAIT.
- ROW_WAIT: on rom_valid, opr1=data_from_ram, opr2=data_from_rom; mac_start=1 for one cycle; go to MAC_WAIT.
- MAC_WAIT: wait for mac_valid. The MultAdder may assert mac_valid in the cycle after mac_start; no minimum wait.
- ACCUM, one cycle, arithmetic:
  - acc = data_from_MultAdder + (sext(b[rowCnt]) <<< BIAS_SHIFT), computed at ACC_W+1 bits.
  - s = acc >>> OUT_SHIFT (arithmetic).
  - If relu_en and s<0, y=0.
  - Else y = s clamped to [-2^(BIT-1), 2^(BIT-1)-1]; any clamping sets sat_flag.
  - Write y into data_to_ram slot rowCnt; rowCnt++.
- NEXT: go to ROW_REQ if rowCnt<n_out_cfg, else DONE.
- DONE: done=1, busy=0; go to IDLE. done stays high in IDLE until the next accepted start.
- Slots rowCnt >= n_out_cfg keep their previous contents.
- n_out_cfg=0 or n_out_cfg>N_OUT: treated as N_OUT.
- rom_valid or mac_valid outside its wait state: ignored.
- Per-neuron latency: 2 + ROM latency + MAC latency + 2 cycles.

Test Plan:
- Setup for all scenarios: BIT=8, N_IN=4, N_OUT=6, BIAS_SHIFT=OUT_SHIFT=4, ROM latency 2, MAC latency 3.
- Basic pass: MAC returns 0x0030 for all rows; biases 0x10; start -> 2 bias reads at bias_addr_base and bias_addr_base+1; every slot 0x13; done after the 6th row; sat_flag=0.
- Addressing: rom_addr_base=0x401, ROW_REVERSE=1 -> row addresses 0x406..0x401 in order; with ROW_REVERSE=0 -> 0x401..0x406.
- Saturation and ReLU:
  - MAC 0x3000, bias 0 -> 0x7F, sat_flag=1.
  - MAC -256, bias 0, relu_en=0 -> 0xF0; relu_en=1 -> 0x00.
  - MAC -0x3000, relu_en=0 -> 0x80, sat_flag=1.
- Partial count: n_out_cfg=3 with data_to_ram preloaded to 0xAA in every slot -> slots 0..2 written; slots 3..5 stay 0xAA; only 1 bias word read.
- Abort and reset:
  - ena=0 during MAC_WAIT -> buses Z next cycle; state IDLE; done=0.
  - iRst_n pulse mid-pass -> all outputs at reset values immediately, without waiting for a clock edge.
  - A fresh start afterwards completes a correct pass.
